// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with a 2-entry skid buffer and synchronous flush.
// Latency: 1 cycle in_data -> out_data when empty; sustains 1 item/cycle.
// Backpressure: in_ready = !skid_valid (registered); it drops only when both entries are held.
// Optional feature macro: PIPE_STAGE_STAT_EN adds the stall_cnt / flush_cnt statistics outputs.
module pipe_stage_buf #(
  parameter int unsigned DATA_W       = 64,
  parameter bit          CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Main entry drives the outputs; skid entry catches the item accepted while main is stalled.
  logic              m_v, s_v;
  logic [DATA_W-1:0] m_d, s_d;
  logic [1:0]        occ_q;

  logic              m_v_nxt, s_v_nxt;
  logic [DATA_W-1:0] m_d_nxt, s_d_nxt;

  logic acc;
  logic pop;

  // in_ready comes straight from the skid flop, so no stall path crosses the stage.
  assign in_ready  = ~s_v;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign occupancy = occ_q;

  assign acc = in_valid & in_ready;
  assign pop = m_v & out_ready;

  // Next-state selection: flush beats everything, then refill main from skid, then
  // load main directly, otherwise park the new item in skid while main holds.
  always_comb begin
    m_v_nxt = m_v;
    s_v_nxt = s_v;
    m_d_nxt = m_d;
    s_d_nxt = s_d;
    if (flush) begin
      // Same-cycle acceptance is dropped; a same-cycle pop was already taken downstream.
      m_v_nxt = 1'b0;
      s_v_nxt = 1'b0;
      if (CLR_ON_FLUSH) begin
        m_d_nxt = '0;
        s_d_nxt = '0;
      end
    end else if (pop && s_v) begin
      // in_ready is low whenever skid is full, so nothing can be accepted here.
      m_v_nxt = 1'b1;
      m_d_nxt = s_d;
      s_v_nxt = 1'b0;
    end else if ((pop || !m_v) && !s_v) begin
      // Main is free (or being freed): new item goes straight to the output register.
      // Payload only moves on acceptance so out_data stays quiet when idle.
      m_v_nxt = acc;
      if (acc) begin
        m_d_nxt = in_data;
      end
    end else if (acc) begin
      // Main is stalled with a valid item: buffer the new one behind it.
      s_v_nxt = 1'b1;
      s_d_nxt = in_data;
    end
  end

  // Entry state and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_v   <= 1'b0;
      s_v   <= 1'b0;
      m_d   <= '0;
      s_d   <= '0;
      occ_q <= 2'd0;
    end else begin
      m_v   <= m_v_nxt;
      s_v   <= s_v_nxt;
      m_d   <= m_d_nxt;
      s_d   <= s_d_nxt;
      occ_q <= {1'b0, m_v_nxt} + {1'b0, s_v_nxt};
    end
  end

`ifdef PIPE_STAGE_STAT_EN
  // Stall counter: cycles where the output holds a valid item that downstream refuses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (m_v && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Flush counter: flushes that actually discarded held entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_cnt <= '0;
    end else if (flush && (occ_q != 2'd0) && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random checks for pipe_stage_buf (DATA_W=16, CLR_ON_FLUSH=1).
// Inputs change 1 time unit after posedge; outputs are compared at that same point.
// Statistics checks are compiled in only with PIPE_STAGE_STAT_EN.
module tb_pipe_stage_buf;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STAT_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .CLR_ON_FLUSH(1'b1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_d   = DW'(k);
      in_data = exp_d;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin failures++; $display("FAIL stream_data k=%0d got_v=%0b got=%h exp=%h", k, out_valid, out_data, exp_d); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occupancy k=%0d got=%0d exp=1", k, occupancy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain got_v=%0b got_occ=%0d exp=0/0", out_valid, occupancy); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_first got_occ=%0d got_rdy=%0b exp=1/1", occupancy, in_ready); end
    in_data = 16'h000B;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL skid_full_occ got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_full_in_ready got=%0b exp=0", in_ready); end
    in_data = 16'h000C;
    tick();
    checks++; if (occupancy !== 2'd2 || out_data !== 16'h000A) begin failures++; $display("FAIL skid_hold got_occ=%0d got=%h exp=2/000a", occupancy, out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 16'h000B || occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_pop1 got=%h occ=%0d rdy=%0b exp=000b/1/1", out_data, occupancy, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h000C) begin failures++; $display("FAIL skid_c_kept got_v=%0b got=%h exp=1/000c", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL skid_empty got_v=%0b occ=%0d exp=0/0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_prefill got=%0d exp=2", occupancy); end
    flush   = 1'b1;
    in_data = 16'h000D;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_state got_v=%0b occ=%0d rdy=%0b exp=0/0/1", out_valid, occupancy, in_ready); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL flush_clr got=%h exp=0", out_data); end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush_d_dropped got_v=%0b occ=%0d exp=0/0", out_valid, occupancy); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    logic          acc, pop;
    prev_hold = 1'b0;
    prev_data = '0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 2);
      in_data   = DW'($urandom);
      checks++; if (occupancy !== 2'(q.size())) begin failures++; $display("FAIL rand_occ c=%0d got=%0d exp=%0d", c, occupancy, q.size()); end
      checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_in_ready c=%0d got=%0b exp=%0b", c, in_ready, (q.size() < 2)); end
      checks++; if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_out_valid c=%0d got=%0b exp=%0b", c, out_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        checks++; if (out_data !== q[0]) begin failures++; $display("FAIL rand_order c=%0d got=%h exp=%h", c, out_data, q[0]); end
      end
      if (prev_hold) begin
        checks++; if (out_data !== prev_data) begin failures++; $display("FAIL rand_stable c=%0d got=%h exp=%h", c, out_data, prev_data); end
      end
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() != 0);
      prev_hold = (q.size() != 0) && !out_ready && !flush;
      prev_data = out_data;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (q.size() != 0) begin
        checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin failures++; $display("FAIL rand_drain got_v=%0b got=%h exp=%h", out_valid, out_data, q[0]); end
        void'(q.pop_front());
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || q.size() != 0) begin failures++; $display("FAIL rand_final got_v=%0b left=%0d exp=0/0", out_valid, q.size()); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL mid_prefill got=%0d exp=2", occupancy); end
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_hs got_v=%0b rdy=%0b exp=0/1", out_valid, in_ready); end
    checks++; if (out_data !== 16'h0 || occupancy !== 2'd0) begin failures++; $display("FAIL mid_reset_data got=%h occ=%0d exp=0/0", out_data, occupancy); end
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL mid_restart got_v=%0b occ=%0d exp=0/0", out_valid, occupancy); end
  endtask

`ifdef PIPE_STAGE_STAT_EN
  task automatic test_stats();
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL stat_reset stall=%0d flush=%0d exp=0/0", stall_cnt, flush_cnt); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL stat_stall got=%0d exp=5", stall_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL stat_flush got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 32'd6) begin failures++; $display("FAIL stat_stall_flush got=%0d exp=6", stall_cnt); end
    tick();
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 32'd6) begin failures++; $display("FAIL stat_idle flush=%0d stall=%0d exp=1/6", flush_cnt, stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_random();
    test_reset_midstream();
`ifdef PIPE_STAGE_STAT_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
